// File: rtl/mc_control_if.sv
// rtl/mc_control_if.sv - control-unit bundle between mc_control and its datapath
interface mc_control_if #(
    parameter int ALUCW = 3
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             memtoreg;
    logic             regdst;
    logic             iord;
    logic             alusrca;
    logic             irwrite;
    logic             memwrite;
    logic             pcwrite;
    logic             branch;
    logic             regwrite;
    logic             illegal;
    logic             timeout;
    logic [1:0]       pcsrc;
    logic [1:0]       alusrcb;
    logic [ALUCW-1:0] alucontrol;
    logic [3:0]       state;

    modport master (
        output op, funct, mem_ready,
        input  memtoreg, regdst, iord, alusrca, irwrite, memwrite, pcwrite,
               branch, regwrite, illegal, timeout, pcsrc, alusrcb, alucontrol, state
    );

    modport slave (
        input  op, funct, mem_ready,
        output memtoreg, regdst, iord, alusrca, irwrite, memwrite, pcwrite,
               branch, regwrite, illegal, timeout, pcsrc, alusrcb, alucontrol, state
    );
endinterface

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle CPU control FSM with memory wait timeout; JUMP_EN enables the JUMP state
module mc_control #(
    parameter int ALUCW       = 3,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          reset,
    mc_control_if.slave   bus
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
`ifdef JUMP_EN
    localparam logic [3:0] S_JUMP    = 4'd11;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    logic [3:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;
    logic [5:0] op_q, op_d;
    logic       in_wait;
    logic [8:0] cnt_inc;

    // Next-state, wait counter and one-shot flag computation
    always_comb begin
        state_d   = S_FETCH;
        cnt_d     = '0;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        op_d      = op_q;
        in_wait   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        cnt_inc   = {1'b0, cnt_q} + 9'd1;
        case (state_q)
            S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = bus.op;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
`ifdef JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default:      illegal_d = 1'b1;
                endcase
            end
            S_MEMADR: begin
                if (op_q == OP_LW)      state_d = S_MEMRD;
                else if (op_q == OP_SW) state_d = S_MEMWR;
            end
            S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
        // A ready on the final allowed cycle still wins over the timeout.
        if (in_wait && !bus.mem_ready) begin
            if (cnt_inc >= 9'(MEM_TIMEOUT)) begin
                state_d   = S_FETCH;
                timeout_d = 1'b1;
            end else begin
                cnt_d = cnt_inc[7:0];
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            op_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            op_q      <= op_d;
        end
    end

    logic [2:0] alu_op;
    logic       funct_bad;

    // State-decoded control outputs; fetch strobes qualify on mem_ready
    always_comb begin
        bus.memtoreg = 1'b0;
        bus.regdst   = 1'b0;
        bus.iord     = 1'b0;
        bus.alusrca  = 1'b0;
        bus.irwrite  = 1'b0;
        bus.memwrite = 1'b0;
        bus.pcwrite  = 1'b0;
        bus.branch   = 1'b0;
        bus.regwrite = 1'b0;
        bus.pcsrc    = 2'b00;
        bus.alusrcb  = 2'b00;
        alu_op       = 3'b000;
        funct_bad    = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.alusrcb = 2'b01;
                alu_op      = ALU_ADD;
                bus.irwrite = bus.mem_ready;
                bus.pcwrite = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                alu_op      = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                alu_op      = ALU_ADD;
            end
            S_MEMRD:   bus.iord = 1'b1;
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                bus.alusrca = 1'b1;
                case (bus.funct)
                    6'b100000: alu_op = 3'b010;
                    6'b100010: alu_op = 3'b110;
                    6'b100100: alu_op = 3'b000;
                    6'b100101: alu_op = 3'b001;
                    6'b101010: alu_op = 3'b111;
                    default: begin
                        alu_op    = ALU_ADD;
                        funct_bad = 1'b1;
                    end
                endcase
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                alu_op      = ALU_SUB;
                bus.branch  = 1'b1;
                bus.pcsrc   = 2'b01;
            end
            S_ADDIWB:  bus.regwrite = 1'b1;
`ifdef JUMP_EN
            S_JUMP: begin
                bus.pcsrc   = 2'b10;
                bus.pcwrite = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.alucontrol = ALUCW'(alu_op);
    assign bus.illegal    = illegal_q | funct_bad;
    assign bus.timeout    = timeout_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - randomized self-checking bench for mc_control against a behavioural model
module tb_mc_control;
    localparam int ALUCW = 4;
    localparam int TMO   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_control_if #(.ALUCW(ALUCW)) bus ();
    mc_control #(.ALUCW(ALUCW), .MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int         m_state;
    int         m_cnt;
    bit         m_ill;
    bit         m_tmo;
    logic [5:0] m_op;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected outputs for the current model state and live inputs
    task automatic model_outputs(input logic [5:0] funct, input bit mr, output logic [22:0] e);
        bit mtr, rd, io, asa, irw, mw, pcw, br, rw, ill, tmo;
        logic [1:0] pcs, asb;
        logic [7:0] alu;
        {mtr, rd, io, asa, irw, mw, pcw, br, rw} = '0;
        pcs = 0; asb = 0; alu = 0;
        ill = m_ill; tmo = m_tmo;
        case (m_state)
            0: begin asb = 1; alu = 2; irw = mr; pcw = mr; end
            1: begin asb = 3; alu = 2; end
            2, 9: begin asa = 1; asb = 2; alu = 2; end
            3: io = 1;
            4: begin mtr = 1; rw = 1; end
            5: begin io = 1; mw = 1; end
            6: begin
                asa = 1;
                if (funct == 32) alu = 2;
                else if (funct == 34) alu = 6;
                else if (funct == 36) alu = 0;
                else if (funct == 37) alu = 1;
                else if (funct == 42) alu = 7;
                else begin alu = 2; ill = 1; end
            end
            7: begin rd = 1; rw = 1; end
            8: begin asa = 1; alu = 6; br = 1; pcs = 1; end
            10: rw = 1;
            11: begin pcs = 2; pcw = 1; end
            default: ;
        endcase
        e = {mtr, rd, io, asa, irw, mw, pcw, br, rw, ill, tmo, pcs, asb, alu};
    endtask

    task automatic model_advance(input bit rst, input logic [5:0] op, input bit mr);
        int  nxt;
        bit  tmo;
        bit  jump_ok;
`ifdef JUMP_EN
        jump_ok = 1;
`else
        jump_ok = 0;
`endif
        if (rst) begin
            m_state = 0; m_cnt = 0; m_ill = 0; m_tmo = 0;
            return;
        end
        m_ill = 0;
        tmo   = 0;
        nxt   = m_state;
        if (m_state == 0 || m_state == 3 || m_state == 5) begin
            if (mr) nxt = (m_state == 0) ? 1 : (m_state == 3) ? 4 : 0;
            else if (m_cnt + 1 >= TMO) begin nxt = 0; tmo = 1; end
            else m_cnt++;
        end else begin
            case (m_state)
                1: begin
                    m_op = op;
                    if (op == 35 || op == 43) nxt = 2;
                    else if (op == 0) nxt = 6;
                    else if (op == 4) nxt = 8;
                    else if (op == 8) nxt = 9;
                    else if (op == 2 && jump_ok) nxt = 11;
                    else begin nxt = 0; m_ill = 1; end
                end
                2: nxt = (m_op == 35) ? 3 : (m_op == 43) ? 5 : 0;
                6: nxt = 7;
                9: nxt = 10;
                default: nxt = 0;
            endcase
        end
        if (nxt != m_state || tmo) m_cnt = 0;
        m_tmo   = tmo;
        m_state = nxt;
    endtask

    // Apply one cycle of inputs, compare against the model, then advance both
    task automatic step(input bit rst, input logic [5:0] op, input logic [5:0] funct, input bit mr);
        logic [22:0] exp;
        logic [22:0] obs;
        reset = rst; bus.op = op; bus.funct = funct; bus.mem_ready = mr;
        #2;
        model_outputs(funct, mr, exp);
        obs = {bus.memtoreg, bus.regdst, bus.iord, bus.alusrca, bus.irwrite, bus.memwrite,
               bus.pcwrite, bus.branch, bus.regwrite, bus.illegal, bus.timeout,
               bus.pcsrc, bus.alusrcb, 8'(bus.alucontrol)};
        check_eq("state", 32'(bus.state), 32'(m_state));
        check_eq("outputs", 32'(obs), 32'(exp));
        model_advance(rst, op, mr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] op_tab [6];
        logic [5:0] fn_tab [5];
        logic [5:0] r_op, r_fn;
        bit         r_mr;
        op_tab = '{6'd35, 6'd43, 6'd0, 6'd4, 6'd8, 6'd2};
        fn_tab = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        m_op = 0;

        reset = 1'b1; bus.op = 0; bus.funct = 0; bus.mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_advance(1, 0, 0);

        // Load word with memory always ready: 0,1,2,3,4,0
        step(1, 6'd35, 6'd0, 1);
        for (int i = 0; i < 6; i++) step(0, 6'd35, 6'd0, 1);

        // Store word with three wait cycles in MEMWR
        step(1, 6'd43, 6'd0, 1);
        step(0, 6'd43, 6'd0, 1);
        step(0, 6'd43, 6'd0, 1);
        step(0, 6'd43, 6'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 6'd43, 6'd0, 0);
        step(0, 6'd43, 6'd0, 1);
        step(0, 6'd43, 6'd0, 0);

        // R-type slt, then unknown funct
        step(1, 6'd0, 6'd42, 1);
        for (int i = 0; i < 4; i++) step(0, 6'd0, 6'd42, 1);
        for (int i = 0; i < 4; i++) step(0, 6'd0, 6'd63, 1);

        // Load word timing out in MEMRD
        step(1, 6'd35, 6'd0, 1);
        for (int i = 0; i < 3; i++) step(0, 6'd35, 6'd0, 1);
        for (int i = 0; i < 6; i++) step(0, 6'd35, 6'd0, 0);

        // Ready arrives on the last allowed wait cycle
        step(1, 6'd35, 6'd0, 1);
        for (int i = 0; i < 3; i++) step(0, 6'd35, 6'd0, 1);
        for (int i = 0; i < TMO - 1; i++) step(0, 6'd35, 6'd0, 0);
        step(0, 6'd35, 6'd0, 1);
        step(0, 6'd35, 6'd0, 1);

        // Jump opcode, and an illegal opcode
        step(1, 6'd2, 6'd0, 1);
        for (int i = 0; i < 4; i++) step(0, 6'd2, 6'd0, 1);
        for (int i = 0; i < 3; i++) step(0, 6'd63, 6'd0, 1);

        // Reset in the middle of a store wait
        step(1, 6'd43, 6'd0, 1);
        for (int i = 0; i < 3; i++) step(0, 6'd43, 6'd0, 1);
        step(0, 6'd43, 6'd0, 0);
        step(1, 6'd43, 6'd0, 0);
        step(0, 6'd43, 6'd0, 0);

        // Fetch timeout re-enters fetch
        step(1, 6'd0, 6'd0, 0);
        for (int i = 0; i < 2 * TMO + 2; i++) step(0, 6'd0, 6'd0, 0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            r_op = ($urandom_range(0, 6) == 6) ? 6'($urandom_range(0, 63)) : op_tab[$urandom_range(0, 5)];
            r_fn = ($urandom_range(0, 5) == 5) ? 6'($urandom_range(0, 63)) : fn_tab[$urandom_range(0, 4)];
            r_mr = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            step($urandom_range(0, 59) == 0, r_op, r_fn, r_mr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
